// File: rtl/ps2_keyq_pkg.sv
// Shared constants and types for the PS/2 key event queue.
package ps2_keyq_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int EVT_W    = 10;
  localparam int CODE_LSB = 0;
  localparam int EXT_BIT  = 8;
  localparam int BRK_BIT  = 9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } dec_state_e;

  // Field order matches EXT_BIT/BRK_BIT/CODE_LSB offsets.
  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/keyq_fifo.sv
// Generic show-ahead register FIFO; head is presented while non-empty, zero otherwise.
module keyq_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = CW - 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = o_empty ? '0 : r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/ps2_key_queue.sv
// PS/2 set-2 prefix decoder feeding a show-ahead key event FIFO.
// Optional held-key bitmap enabled by PS2_KEYQ_HELD_MAP_EN.
module ps2_key_queue
  import ps2_keyq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic [7:0]    ps2_key_data,
  input  logic          ps2_key_pressed,
  input  logic          evt_ready,
  input  logic          clear_ovf,
  output logic          evt_valid,
  output logic [7:0]    evt_code,
  output logic          evt_ext,
  output logic          evt_break,
  output logic [7:0]    last_key,
  output logic [CW-1:0] count,
  output logic          overflow
`ifdef PS2_KEYQ_HELD_MAP_EN
  ,
  output logic [127:0]  held_map
`endif
);

  dec_state_e r_state, w_state_nxt;
  logic       w_evt;
  key_evt_t   w_evt_data;
  key_evt_t   w_head;
  logic       w_full, w_empty, w_drop;
  logic [7:0] r_last_key;
  logic       r_ovf;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Prefixes accumulate in either order; any other byte closes the event.
  always_comb begin
    w_state_nxt = r_state;
    w_evt       = 1'b0;
    w_evt_data  = '0;
    if (ps2_key_pressed) begin
      case (ps2_key_data)
        PS2_EXT: begin
          if (r_state == S_IDLE)     w_state_nxt = S_EXT;
          else if (r_state == S_BRK) w_state_nxt = S_EXT_BRK;
        end
        PS2_BRK: begin
          if (r_state == S_IDLE)     w_state_nxt = S_BRK;
          else if (r_state == S_EXT) w_state_nxt = S_EXT_BRK;
        end
        default: begin
          w_evt           = 1'b1;
          w_evt_data.code = ps2_key_data;
          w_evt_data.ext  = (r_state == S_EXT) || (r_state == S_EXT_BRK);
          w_evt_data.brk  = (r_state == S_BRK) || (r_state == S_EXT_BRK);
          w_state_nxt     = S_IDLE;
        end
      endcase
    end
  end

  keyq_fifo #(
    .W     (EVT_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .i_push  (w_evt),
    .i_din   (w_evt_data),
    .i_pop   (evt_ready),
    .o_dout  (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Full implies non-empty, so a raised evt_ready always frees a slot.
  assign w_drop = w_evt & w_full & ~evt_ready;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_last_key <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_evt && !w_evt_data.brk) r_last_key <= w_evt_data.code;
      if (clear_ovf)   r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef PS2_KEYQ_HELD_MAP_EN
  logic [127:0] r_held_map;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_held_map <= '0;
    end else if (w_evt && !w_evt_data.ext && !w_evt_data.code[7]) begin
      r_held_map[w_evt_data.code[6:0]] <= ~w_evt_data.brk;
    end
  end

  assign held_map = r_held_map;
`endif

  assign evt_valid = ~w_empty;
  assign evt_code  = w_head.code;
  assign evt_ext   = w_head.ext;
  assign evt_break = w_head.brk;
  assign last_key  = r_last_key;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_ps2_key_queue.sv
// Scoreboard bench for ps2_key_queue; map checks active with PS2_KEYQ_HELD_MAP_EN.
module tb_ps2_key_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLOCK_50 = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    ps2_key_data = '0;
  logic          ps2_key_pressed = 1'b0;
  logic          evt_ready = 1'b0;
  logic          clear_ovf = 1'b0;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_break;
  logic [7:0]    last_key;
  logic [CW-1:0] count;
  logic          overflow;
`ifdef PS2_KEYQ_HELD_MAP_EN
  logic [127:0]  held_map;
`endif

  ps2_key_queue #(.DEPTH(DEPTH)) dut (
    .CLOCK_50        (CLOCK_50),
    .resetn          (resetn),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .evt_ready       (evt_ready),
    .clear_ovf       (clear_ovf),
    .evt_valid       (evt_valid),
    .evt_code        (evt_code),
    .evt_ext         (evt_ext),
    .evt_break       (evt_break),
    .last_key        (last_key),
    .count           (count),
    .overflow        (overflow)
`ifdef PS2_KEYQ_HELD_MAP_EN
    ,
    .held_map        (held_map)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0;
  int n_err = 0;

  bit           m_ext, m_brk, m_ovf;
  logic [7:0]   m_last;
  logic [127:0] m_map;
  logic [9:0]   sb[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    chk("valid", evt_valid, sb.size() != 0);
    chk("count", count, sb.size());
    chk("last_key", last_key, m_last);
    chk("overflow", overflow, m_ovf);
    if (sb.size() != 0) chk("head", {evt_break, evt_ext, evt_code}, sb[0]);
    else                chk("empty_out", {evt_break, evt_ext, evt_code}, 0);
`ifdef PS2_KEYQ_HELD_MAP_EN
    chk("held_map", held_map, m_map);
`endif
  endtask

  // Runs one cycle from a falling edge; the model is updated with the same
  // pop-then-push ordering the queue sees within that cycle.
  task automatic step(input bit stb, input logic [7:0] b, input bit rdy, input bit clr);
    bit drop;
    drop = 1'b0;
    if (rdy) begin
      if (sb.size() != 0) begin
        chk("pop_head", {evt_break, evt_ext, evt_code}, sb[0]);
        void'(sb.pop_front());
      end else begin
        chk("pop_empty", evt_valid, 0);
      end
    end
    if (stb) begin
      if (b == 8'hE0)      m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        if (!m_brk) m_last = b;
        if (!m_ext && b < 8'h80) m_map[b[6:0]] = !m_brk;
        if (sb.size() < DEPTH) sb.push_back({m_brk, m_ext, b});
        else                   drop = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
    if (clr)       m_ovf = 1'b0;
    else if (drop) m_ovf = 1'b1;
    ps2_key_pressed = stb;
    ps2_key_data    = b;
    evt_ready       = rdy;
    clear_ovf       = clr;
    @(negedge CLOCK_50);
    ps2_key_pressed = 1'b0;
    ps2_key_data    = '0;
    evt_ready       = 1'b0;
    clear_ovf       = 1'b0;
    check_state();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    m_ext = 0; m_brk = 0; m_ovf = 0; m_last = '0; m_map = '0;
    sb.delete();
    check_state();
  endtask

  task automatic drain();
    while (sb.size() != 0) step(0, 8'h00, 1, 0);
  endtask

  initial begin
    m_map = '0;
    m_last = '0;
    @(negedge CLOCK_50);
    do_reset();

    // single make
    step(1, 8'h1C, 0, 0);
    chk("a_code", evt_code, 8'h1C);
    chk("a_count", count, 1);
    drain();

    // extended break, then the other prefix order and repeated prefixes
    step(1, 8'hE0, 0, 0);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h75, 0, 0);
    chk("eb_flags", {evt_ext, evt_break, last_key}, {2'b11, 8'h1C});
    step(1, 8'hF0, 0, 0);
    step(1, 8'hE0, 0, 0);
    step(1, 8'hE0, 0, 0);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h6B, 0, 0);
    step(1, 8'hE1, 0, 0);
    step(1, 8'hAA, 0, 0);
    step(1, 8'hFA, 0, 0);
    drain();
    step(0, 8'h00, 1, 0);

    // overflow on ninth push, ordered drain
    for (int i = 0; i < 9; i++) step(1, 8'h10 + 8'(i), 0, 0);
    chk("ovf_count", count, DEPTH);
    chk("ovf_last", last_key, 8'h18);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_order", evt_code, 8'h10 + 8'(i));
      step(0, 8'h00, 1, 0);
    end
    chk("ovf_drained", evt_valid, 0);
    step(0, 8'h00, 0, 1);

    // clear beats a same-cycle drop; push+pop while full never drops
    for (int i = 0; i < DEPTH; i++) step(1, 8'h20 + 8'(i), 0, 0);
    step(1, 8'h31, 0, 1);
    step(1, 8'h29, 1, 0);
    chk("pp_full_count", count, DEPTH);
    chk("pp_full_ovf", overflow, 0);
    step(1, 8'h2A, 1, 0);
    step(0, 8'h00, 1, 0);
    step(1, 8'h2B, 1, 0);
    drain();

    // reset discards a pending prefix
    step(1, 8'hE0, 0, 0);
    do_reset();
    step(1, 8'h1C, 0, 0);
    chk("rst_ext", {evt_ext, evt_code}, {1'b0, 8'h1C});
    drain();

    // back-to-back random traffic with random pops
    for (int i = 0; i < 200; i++) begin
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 9);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, b, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end
    drain();

`ifdef PS2_KEYQ_HELD_MAP_EN
    step(1, 8'h1C, 1, 0);
    chk("map_make", held_map[8'h1C], 1);
    step(1, 8'hF0, 1, 0);
    step(1, 8'h1C, 1, 0);
    chk("map_break", held_map[8'h1C], 0);
    step(1, 8'hE0, 1, 0);
    step(1, 8'h1C, 1, 0);
    chk("map_ext", held_map[8'h1C], 0);
    step(1, 8'h83, 1, 0);
    chk("map_hi", held_map, m_map);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
